// File: rtl/fpu_seq_ctrl.sv
// Sequencing controller for the add/sub/mul/div float cores: one request at a time,
// one-shot issue pulse, wait for the core's result, return it. Optional WAIT abort: `FPU_SEQ_TIMEOUT_EN`.
module fpu_seq_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  output logic [3:0]       core_sel,
  input  logic [3:0]       core_tvalid,
  input  logic [31:0]      core_add_data,
  input  logic [31:0]      core_sub_data,
  input  logic [31:0]      core_mul_data,
  input  logic [31:0]      core_div_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [1:0]       resp_op,
  output logic             resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  op_reg;
  logic [31:0] sel_data;
  logic        hit;
  logic        timeout_hit;

  always_comb begin
    sel_data = core_add_data;
    case (op_reg)
      2'd0: sel_data = core_add_data;
      2'd1: sel_data = core_sub_data;
      2'd2: sel_data = core_mul_data;
      2'd3: sel_data = core_div_data;
      default: sel_data = core_add_data;
    endcase
  end

  // Only the issued core's tvalid matters; other bits may carry stale results.
  assign hit       = core_tvalid[op_reg];
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;
  logic       err_reg;
  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign resp_err    = err_reg;
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT_CYC > 0);
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_reg     <= 2'd0;
      core_a     <= 32'd0;
      core_b     <= 32'd0;
      core_sel   <= 4'd0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_op    <= 2'd0;
      op_count   <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
      wait_cnt   <= 8'd0;
      err_reg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_reg   <= req_op;
            core_a   <= req_a;
            core_b   <= req_b;
            core_sel <= 4'b0001 << req_op;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          core_sel <= 4'd0;
`ifdef FPU_SEQ_TIMEOUT_EN
          wait_cnt <= 8'd0;
`endif
          state    <= WAIT;
        end
        WAIT: begin
          // A result arriving on the final allowed cycle beats the abort.
          if (hit) begin
            resp_data  <= sel_data;
            resp_op    <= op_reg;
            resp_valid <= 1'b1;
`ifdef FPU_SEQ_TIMEOUT_EN
            err_reg    <= 1'b0;
`endif
            state      <= RESP;
          end else if (timeout_hit) begin
            resp_data  <= 32'h7FC0_0000;
            resp_op    <= op_reg;
            resp_valid <= 1'b1;
`ifdef FPU_SEQ_TIMEOUT_EN
            err_reg    <= 1'b1;
`endif
            state      <= RESP;
          end else begin
`ifdef FPU_SEQ_TIMEOUT_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed bench for fpu_seq_ctrl with a latency-programmable core model.
// Timeout cases run only when FPU_SEQ_TIMEOUT_EN is defined.
module tb_fpu_seq_ctrl;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [31:0]   req_a = 32'd0, req_b = 32'd0;
  logic [31:0]   core_a, core_b;
  logic [3:0]    core_sel;
  logic [3:0]    core_tvalid;
  logic [31:0]   core_add_data = 32'd0, core_sub_data = 32'd0;
  logic [31:0]   core_mul_data = 32'd0, core_div_data = 32'd0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_data;
  logic [1:0]    resp_op;
  logic          resp_err;
  logic          busy;
  logic [CW-1:0] op_count;

  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_count = '0;

  // Core model: tvalid pulses L cycles after the issue pulse; L=0 never responds.
  int            core_lat = 1;
  int            cd = 0;
  logic [1:0]    op_m = 2'd0;
  logic [3:0]    model_tv = 4'd0;
  logic [3:0]    extra_tv = 4'd0;

  assign core_tvalid = model_tv | extra_tv;

  always #5 clk = ~clk;

  fpu_seq_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .core_a(core_a), .core_b(core_b), .core_sel(core_sel),
    .core_tvalid(core_tvalid),
    .core_add_data(core_add_data), .core_sub_data(core_sub_data),
    .core_mul_data(core_mul_data), .core_div_data(core_div_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_op(resp_op), .resp_err(resp_err), .busy(busy), .op_count(op_count)
  );

  always @(posedge clk) begin
    model_tv <= 4'd0;
    if (core_sel != 4'd0 && core_lat > 0) begin
      op_m <= core_sel[1] ? 2'd1 : core_sel[2] ? 2'd2 : core_sel[3] ? 2'd3 : 2'd0;
      if (core_lat == 1) model_tv <= core_sel;
      else cd <= core_lat - 1;
    end else if (cd > 1) begin
      cd <= cd - 1;
    end else if (cd == 1) begin
      cd <= 0;
      model_tv <= 4'b0001 << op_m;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_core_sel"}, 32'(core_sel), 32'd0);
    check({tag, "_core_ab"}, core_a | core_b, 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_data"}, resp_data, 32'd0);
    check({tag, "_resp_op_err"}, {29'd0, resp_op, resp_err}, 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_data, input logic exp_err,
                        input int bp);
    logic [3:0]  onehot;
    logic [31:0] d0;
    int          k, exp_k;
    logic        got, rdy_bad, sel_bad, hold_bad;
    onehot = 4'b0001 << op;
    exp_k  = (lat == 0) ? TO + 2 : lat + 2;
    core_add_data = 32'hBAD0_0000;
    core_sub_data = 32'hBAD0_0001;
    core_mul_data = 32'hBAD0_0002;
    core_div_data = 32'hBAD0_0003;
    case (op)
      2'd0: core_add_data = exp_data;
      2'd1: core_sub_data = exp_data;
      2'd2: core_mul_data = exp_data;
      default: core_div_data = exp_data;
    endcase
    core_lat   = lat;
    resp_ready = (bp == 0);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0; req_a = ~a; req_b = ~b;
    k = 0; got = 1'b0; rdy_bad = 1'b0; sel_bad = 1'b0;
    while (!got && k < 300) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("core_sel_pulse", 32'(core_sel), 32'(onehot));
        check("core_a", core_a, a);
        check("core_b", core_b, b);
      end else if (core_sel != 4'd0) sel_bad = 1'b1;
      if (req_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
      // Stale pulses on the other cores during WAIT must not complete the op.
      extra_tv = (k == 3 && (lat > 4 || lat == 0)) ? ~onehot : 4'd0;
      if (resp_valid === 1'b1) got = 1'b1;
    end
    extra_tv = 4'd0;
    check("resp_valid_seen", 32'(got), 32'd1);
    if (!got) return;
    check("latency", 32'(k), 32'(exp_k));
    check("core_sel_once", 32'(sel_bad), 32'd0);
    check("busy_not_ready", 32'(rdy_bad), 32'd0);
    check("resp_data", resp_data, exp_data);
    check("resp_op", 32'(resp_op), 32'(op));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("core_a_hold", core_a, a);
    if (bp > 0) begin
      d0 = resp_data;
      hold_bad = 1'b0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        extra_tv = (i == 5) ? 4'hF : 4'd0;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== d0 ||
            resp_op !== op || op_count !== exp_count) hold_bad = 1'b1;
      end
      extra_tv = 4'd0;
      check("bp_hold", 32'(hold_bad), 32'd0);
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_count = exp_count + 1'b1;
    check("op_count", 32'(op_count), 32'(exp_count));
    check("idle_after_hs", {30'd0, req_ready, resp_valid}, 32'd2);
    $display("op=%0d a=%h b=%h data=%h err=%0d lat=%0d count=%0d",
             op, a, b, resp_data, resp_err, k, op_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 11, 32'h4040_0000, 1'b0, 0);
    run_op(2'd1, 32'h4040_0000, 32'h3F80_0000, 6, 32'h4000_0000, 1'b0, 0);
    run_op(2'd2, 32'h4000_0000, 32'h4040_0000, 3, 32'h40C0_0000, 1'b0, 0);
    run_op(2'd3, 32'h3F80_0000, 32'h4080_0000, 7, 32'h3E80_0000, 1'b0, 0);
    check("count_after_four", 32'(op_count), 32'd4);

    run_op(2'd2, 32'h4000_0000, 32'h4000_0000, 5, 32'h4080_0000, 1'b0, 20);

    // Reset five cycles into a divide; its late result must be dropped.
    core_lat = 20;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd3; req_a = 32'h3F80_0000; req_b = 32'h4080_0000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("stale_after_rst", 32'(bad), 32'd0);
    $display("op=3 reset mid-wait, late result dropped count=%0d", op_count);

`ifdef FPU_SEQ_TIMEOUT_EN
    run_op(2'd1, 32'h4040_0000, 32'h3F80_0000, 0, 32'h7FC0_0000, 1'b1, 0);
    run_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, TO, 32'h4000_0000, 1'b0, 0);
`else
    core_lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'h4040_0000; req_b = 32'h3F80_0000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (busy !== 1'b1 || resp_valid !== 1'b0) bad = 1'b1;
    end
    check("wait_forever", 32'(bad), 32'd0);
    $display("op=1 no core response, busy held 1000 cycles");
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    exp_count = '0;
`endif

    // 4-bit counter: from a cleared count, 17 completions wrap to 1.
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    exp_count = '0;
    for (int i = 0; i < 17; i++)
      run_op(2'(i % 4), 32'h3F80_0000 + 32'(i), 32'h4000_0000, 1 + (i % 3),
             32'h1000_0000 + 32'(i), 1'b0, 0);
    check("count_wrap", 32'(op_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
